// File: rtl/light_centroid.sv
// light_centroid: classifies RGB565 pixels as lit by luma threshold,
// accumulates lit-pixel coordinate sums and count per frame, and at frame
// end divides sums by count (32-step restoring divider) to report one
// centroid sample per frame with a single-cycle valid pulse.
module light_centroid #(
   parameter int H_LAST     = 1279,
   parameter int V_LAST     = 719,
   parameter int THRESHOLD  = 160,
   parameter int MIN_PIXELS = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic [15:0] pixel_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [19:0] count_out,
   output logic        light_out,
   output logic        valid_out,
   output logic        busy_out
);

   localparam logic [7:0]  LP_THR   = 8'(THRESHOLD);
   localparam logic [10:0] LP_HLAST = 11'(H_LAST);
   localparam logic [9:0]  LP_VLAST = 10'(V_LAST);
   localparam logic [19:0] LP_MIN   = 20'(MIN_PIXELS);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   // Luma approximation: 2*R5 + G6 + 2*B5, fits in 8 bits (max 187).
   function automatic logic [7:0] luma_f(input logic [15:0] px);
      luma_f = {2'b00, px[15:11], 1'b0} + {2'b00, px[10:5]} + {2'b00, px[4:0], 1'b0};
   endfunction

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_iter;

   logic [30:0] r_sum_x;
   logic [29:0] r_sum_y;
   logic [19:0] r_cnt;

   logic [31:0] r_qx;
   logic [31:0] r_qy;
   logic [19:0] r_rx;
   logic [19:0] r_ry;
   logic [19:0] r_dvs;

   logic [10:0] r_x;
   logic [9:0]  r_y;
   logic [19:0] r_count;
   logic        r_light;
   logic        r_valid;

   logic        w_lit;
   logic        w_frame_end;
   logic        w_start;
   logic [30:0] w_sum_x_nxt;
   logic [29:0] w_sum_y_nxt;
   logic [19:0] w_cnt_nxt;

   logic        w_busy;
   logic        w_div;
   logic        w_done;
   logic        w_last_iter;

   logic [20:0] w_shx;
   logic [20:0] w_shy;
   logic [20:0] w_subx;
   logic [20:0] w_suby;
   logic        w_bit_x;
   logic        w_bit_y;

   // Pixel classification and the accumulator values including this pixel.
   always_comb begin
      w_lit       = valid_in && (luma_f(pixel_in) >= LP_THR);
      w_frame_end = valid_in && (hcount_in == LP_HLAST) && (vcount_in == LP_VLAST);
      w_start     = w_frame_end && (r_state == S_IDLE);
      w_sum_x_nxt = r_sum_x + (w_lit ? {20'd0, hcount_in} : 31'd0);
      w_sum_y_nxt = r_sum_y + (w_lit ? {20'd0, vcount_in} : 30'd0);
      w_cnt_nxt   = r_cnt + (w_lit ? 20'd1 : 20'd0);
   end

   // Frame accumulators; cleared after every frame end, even a dropped one.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sum_x <= '0;
         r_sum_y <= '0;
         r_cnt   <= '0;
      end else if (w_frame_end) begin
         r_sum_x <= '0;
         r_sum_y <= '0;
         r_cnt   <= '0;
      end else begin
         r_sum_x <= w_sum_x_nxt;
         r_sum_y <= w_sum_y_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // One restoring-division step for both quotients.
   always_comb begin
      w_shx   = {r_rx, r_qx[31]};
      w_shy   = {r_ry, r_qy[31]};
      w_bit_x = (w_shx >= {1'b0, r_dvs});
      w_bit_y = (w_shy >= {1'b0, r_dvs});
      w_subx  = w_shx - {1'b0, r_dvs};
      w_suby  = w_shy - {1'b0, r_dvs};
   end

   // Divider datapath: snapshot operands at frame end, then shift quotients in.
   always_ff @(posedge clk_in) begin
      if (w_start) begin
         r_qx  <= {1'b0, w_sum_x_nxt};
         r_qy  <= {2'b00, w_sum_y_nxt};
         r_rx  <= '0;
         r_ry  <= '0;
         r_dvs <= w_cnt_nxt;
      end else if (w_div) begin
         r_qx <= {r_qx[30:0], w_bit_x};
         r_qy <= {r_qy[30:0], w_bit_y};
         r_rx <= 20'(w_bit_x ? w_subx : w_shx);
         r_ry <= 20'(w_bit_y ? w_suby : w_shy);
      end
   end

   // FSM state register and iteration counter.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_div) r_iter <= r_iter + 5'd1;
         else       r_iter <= '0;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_last_iter = (r_iter == 5'd31);
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_DIV;
         S_DIV:   if (w_last_iter) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state decode.
   always_comb begin
      w_busy = (r_state != S_IDLE);
      w_div  = (r_state == S_DIV);
      w_done = (r_state == S_DONE);
   end

   // Result registers; position held when the frame had too few lit pixels.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_x     <= '0;
         r_y     <= '0;
         r_count <= '0;
         r_light <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_done;
         if (w_done) begin
            r_count <= r_dvs;
            if (r_dvs >= LP_MIN) begin
               r_light <= 1'b1;
               r_x     <= r_qx[10:0];
               r_y     <= r_qy[9:0];
            end else begin
               r_light <= 1'b0;
            end
         end
      end
   end

   assign x_out     = r_x;
   assign y_out     = r_y;
   assign count_out = r_count;
   assign light_out = r_light;
   assign valid_out = r_valid;
   assign busy_out  = w_busy;

endmodule
